// File: rtl/iotdf_pkg.sv
// -----------------------------------------------------------------------------
// iotdf_pkg
// Shared definitions for the IoT data filter:
//   - geometry of a sample / round
//   - fn_sel function codes
//   - the 128-bit range thresholds used by the Extract and Exclude functions
//   - small unsigned compare helpers
// -----------------------------------------------------------------------------
package iotdf_pkg;

    localparam int SAMPLE_W          = 128;
    localparam int BYTE_W            = 8;
    localparam int BYTES_PER_SAMPLE  = SAMPLE_W / BYTE_W;   // 16
    localparam int SAMPLES_PER_ROUND = 8;
    localparam int ROUND_IDX_W       = 3;                   // log2(SAMPLES_PER_ROUND)
    // Eight 128-bit samples need three extra bits to sum without overflow.
    localparam int ACC_W             = SAMPLE_W + ROUND_IDX_W;

    typedef enum logic [2:0] {
        FN_NONE    = 3'd0,
        FN_MAX     = 3'd1,
        FN_MIN     = 3'd2,
        FN_AVG     = 3'd3,
        FN_EXTRACT = 3'd4,
        FN_EXCLUDE = 3'd5,
        FN_PMAX    = 3'd6,
        FN_PMIN    = 3'd7
    } fn_e;

    // Extract passes samples strictly inside (LOW4, HIGH4).
    localparam logic [SAMPLE_W-1:0] LOW4  = {4'h6, {(SAMPLE_W-4){1'b1}}};
    localparam logic [SAMPLE_W-1:0] HIGH4 = {4'hA, {(SAMPLE_W-4){1'b1}}};
    // Exclude passes samples strictly outside [LOW5, HIGH5].
    localparam logic [SAMPLE_W-1:0] LOW5  = {4'h7, {(SAMPLE_W-4){1'b1}}};
    localparam logic [SAMPLE_W-1:0] HIGH5 = {4'hB, {(SAMPLE_W-4){1'b1}}};

    function automatic logic [SAMPLE_W-1:0] umax(input logic [SAMPLE_W-1:0] a,
                                                 input logic [SAMPLE_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [SAMPLE_W-1:0] umin(input logic [SAMPLE_W-1:0] a,
                                                 input logic [SAMPLE_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/iotdf_byte_assembler.sv
// -----------------------------------------------------------------------------
// iotdf_byte_assembler
// Collects 16 bytes (most-significant first) into one 128-bit sample.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   in_en        in   byte_in is valid this cycle
//   byte_in      in   8-bit input byte
//   sample       out  128-bit sample formed by the stored bytes plus byte_in
//   sample_done  out  high in the cycle whose byte_in completes a sample;
//                     'sample' then holds the complete value, so the parent
//                     can register its result on the same edge
// -----------------------------------------------------------------------------
module iotdf_byte_assembler
    import iotdf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_en,
    input  logic [BYTE_W-1:0]   byte_in,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_done
);

    localparam int CNT_W = $clog2(BYTES_PER_SAMPLE);

    // Only the 15 most recent bytes need storage: the 16th byte of a sample is
    // consumed straight from byte_in via the 'shifted' view below.
    logic [SAMPLE_W-BYTE_W-1:0] shift_reg;
    logic [CNT_W-1:0]           byte_cnt_reg;
    logic [SAMPLE_W-1:0]        shifted;

    assign shifted[BYTE_W-1:0] = byte_in;

    generate
        for (genvar gi = 1; gi < BYTES_PER_SAMPLE; gi++) begin : g_byte_lane
            assign shifted[gi*BYTE_W +: BYTE_W] = shift_reg[(gi-1)*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg    <= '0;
            byte_cnt_reg <= '0;
        end else if (in_en) begin
            shift_reg    <= shifted[SAMPLE_W-BYTE_W-1:0];
            // Wraps naturally from 15 back to 0 at the end of each sample.
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
        end
    end

    assign sample      = shifted;
    assign sample_done = in_en && (byte_cnt_reg == CNT_W'(BYTES_PER_SAMPLE - 1));

endmodule

// File: rtl/iotdf.sv
// -----------------------------------------------------------------------------
// iotdf
// IoT data filter. Bytes stream in 16 per 128-bit sample, 8 samples per round;
// fn_sel chooses the reduction or filter applied.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low
//   in_en    in   iot_in carries a valid byte this cycle
//   iot_in   in   input byte, most-significant byte of a sample first
//   fn_sel   in   function select (see iotdf_pkg::fn_e), static during a run
//   busy     out  always 0: one byte per cycle is always accepted
//   valid    out  one-cycle strobe, iot_out holds a fresh result
//   iot_out  out  128-bit result, held until the next result
// -----------------------------------------------------------------------------
module iotdf
    import iotdf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_en,
    input  logic [BYTE_W-1:0]   iot_in,
    input  logic [2:0]          fn_sel,
    output logic                busy,
    output logic                valid,
    output logic [SAMPLE_W-1:0] iot_out
);

    // ---------------------------------------------------------------- assembly
    logic [SAMPLE_W-1:0] sample;
    logic                sample_done;

    iotdf_byte_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .in_en       (in_en),
        .byte_in     (iot_in),
        .sample      (sample),
        .sample_done (sample_done)
    );

    // ------------------------------------------------------------------- state
    logic                   valid_reg;
    logic [SAMPLE_W-1:0]    out_reg;
    logic [ROUND_IDX_W-1:0] round_idx_reg;     // sample position within round
    logic [ACC_W-1:0]       acc_reg;
    logic [SAMPLE_W-1:0]    max_reg;
    logic [SAMPLE_W-1:0]    min_reg;
    logic [SAMPLE_W-1:0]    peak_reg;
    logic                   peak_seen_reg;     // a peak has been stored since reset

    // --------------------------------------------------- per-sample next values
    logic                first_sample;
    logic                last_sample;
    logic [SAMPLE_W-1:0] max_next;
    logic [SAMPLE_W-1:0] min_next;
    logic [ACC_W-1:0]    acc_next;
    logic [SAMPLE_W-1:0] avg_next;
    fn_e                 fn;

    assign fn           = fn_e'(fn_sel);
    assign first_sample = (round_idx_reg == '0);
    assign last_sample  = (round_idx_reg == ROUND_IDX_W'(SAMPLES_PER_ROUND - 1));

    // The first sample of a round seeds the running values, so no constant
    // (all-ones / all-zeros) ever leaks into a result.
    assign max_next = first_sample ? sample : umax(max_reg, sample);
    assign min_next = first_sample ? sample : umin(min_reg, sample);
    assign acc_next = first_sample ? {{ROUND_IDX_W{1'b0}}, sample}
                                   : acc_reg + {{ROUND_IDX_W{1'b0}}, sample};
    // Divide by 8 by dropping the low bits; the upper 128 bits always fit.
    assign avg_next = acc_next[ACC_W-1:ROUND_IDX_W];

    // ---------------------------------------------------------- output decision
    logic                emit;
    logic                peak_update;
    logic [SAMPLE_W-1:0] result;

    always_comb begin
        emit        = 1'b0;
        peak_update = 1'b0;
        result      = '0;
        if (sample_done) begin
            case (fn)
                FN_MAX: begin
                    emit   = last_sample;
                    result = max_next;
                end
                FN_MIN: begin
                    emit   = last_sample;
                    result = min_next;
                end
                FN_AVG: begin
                    emit   = last_sample;
                    result = avg_next;
                end
                FN_EXTRACT: begin
                    emit   = (sample > LOW4) && (sample < HIGH4);
                    result = sample;
                end
                FN_EXCLUDE: begin
                    emit   = (sample < LOW5) || (sample > HIGH5);
                    result = sample;
                end
                FN_PMAX: begin
                    // First completed round always publishes; later rounds
                    // only when they set a new, strictly higher peak.
                    peak_update = last_sample && (!peak_seen_reg || (max_next > peak_reg));
                    emit        = peak_update;
                    result      = max_next;
                end
                FN_PMIN: begin
                    peak_update = last_sample && (!peak_seen_reg || (min_next < peak_reg));
                    emit        = peak_update;
                    result      = min_next;
                end
                default: begin
                    emit   = 1'b0;
                    result = '0;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg     <= 1'b0;
            out_reg       <= '0;
            round_idx_reg <= '0;
            acc_reg       <= '0;
            max_reg       <= '0;
            min_reg       <= '0;
            peak_reg      <= '0;
            peak_seen_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (sample_done) begin
                // Wraps 7 -> 0, starting the next round.
                round_idx_reg <= round_idx_reg + 1'b1;
                acc_reg       <= acc_next;
                max_reg       <= max_next;
                min_reg       <= min_next;
            end
            if (emit) begin
                valid_reg <= 1'b1;
                out_reg   <= result;
            end
            if (peak_update) begin
                peak_reg      <= result;
                peak_seen_reg <= 1'b1;
            end
        end
    end

    assign busy    = 1'b0;
    assign valid   = valid_reg;
    assign iot_out = out_reg;

endmodule

// File: tb/tb_iotdf.sv
// -----------------------------------------------------------------------------
// tb_iotdf
// Scoreboard bench for iotdf. Stimulus tasks push the expected result (value
// and the cycle in which valid must be seen) whenever a sent sample should
// produce output; the monitor pops and compares on every valid pulse.
// -----------------------------------------------------------------------------
module tb_iotdf;
    import iotdf_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_en = 1'b0;
    logic [7:0]   iot_in = 8'h00;
    logic [2:0]   fn_sel = 3'd0;
    logic         busy;
    logic         valid;
    logic [127:0] iot_out;

    iotdf dut (
        .clk     (clk),
        .rst     (rst),
        .in_en   (in_en),
        .iot_in  (iot_in),
        .fn_sel  (fn_sel),
        .busy    (busy),
        .valid   (valid),
        .iot_out (iot_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] val;
        int unsigned  cyc;
        string        name;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           fails  = 0;
    int unsigned  last_cap = 0;
    bit           done_flag = 1'b0;
    bit           final_done = 1'b0;
    logic [127:0] round_buf [8];

    localparam logic [127:0] ALL_F = {128{1'b1}};

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (valid !== 1'b0 || iot_out !== 128'd0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: valid=%b busy=%b iot_out=%h, required 0/0/0",
                         valid, busy, iot_out);
            end
            if (sb_q.size() != 0) begin
                checks++;
                fails++;
                $display("FAIL pending_at_reset: %0d expected results never seen, required 0",
                         sb_q.size());
                sb_q.delete();
            end
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL busy: got %b, required 0", busy);
            end
            if (valid !== 1'b0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid: cycle %0d iot_out=%h, required no valid",
                             cyc, iot_out);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (iot_out !== e.val || cyc != e.cyc || valid !== 1'b1) begin
                        fails++;
                        $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                                 e.name, iot_out, cyc, e.val, e.cyc);
                    end else begin
                        $display("ok   %s: iot_out=%h cycle %0d", e.name, iot_out, cyc);
                    end
                end
            end
        end
        if (done_flag && !final_done) begin
            checks++;
            final_done = 1'b1;
            if (sb_q.size() != 0) begin
                fails++;
                $display("FAIL missing_valid: %0d expected results never seen, next %s=%h",
                         sb_q.size(), sb_q[0].name, sb_q[0].val);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            int n;
            n = $urandom_range(0, 2);
            repeat (n) begin
                in_en  = 1'b0;
                iot_in = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        iot_in = b;
        in_en  = 1'b1;
        @(posedge clk); #1;
        in_en  = 1'b0;
        last_cap = cyc;
    endtask

    task automatic send_sample(input logic [127:0] v, input bit gaps);
        for (int b = 15; b >= 0; b--) send_byte(v[b*8 +: 8], gaps);
    endtask

    task automatic send_round(input bit gaps);
        for (int s = 0; s < 8; s++) send_sample(round_buf[s], gaps);
    endtask

    task automatic expect_out(input logic [127:0] v, input string name);
        exp_t e;
        e.val  = v;
        e.cyc  = last_cap;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic set_round(input logic [127:0] a0, input logic [127:0] a1,
                             input logic [127:0] a2, input logic [127:0] a3,
                             input logic [127:0] a4, input logic [127:0] a5,
                             input logic [127:0] a6, input logic [127:0] a7);
        round_buf[0] = a0; round_buf[1] = a1; round_buf[2] = a2; round_buf[3] = a3;
        round_buf[4] = a4; round_buf[5] = a5; round_buf[6] = a6; round_buf[7] = a7;
    endtask

    task automatic apply_reset(input logic [2:0] fn);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        fn_sel = fn;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Power-on reset; the monitor checks cleared outputs while rst is low.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // ---- Max: {1,9,3,0,...}; second round re-seeds from its own samples
        apply_reset(FN_MAX);
        set_round(1, 9, 3, 0, 0, 0, 0, 0);
        send_round(0); expect_out(128'd9, "max_r1");
        set_round(2, 1, 0, 1, 2, 0, 1, 0);
        send_round(0); expect_out(128'd2, "max_r2_seed");
        // Partial round left behind must produce nothing.
        for (int s = 0; s < 5; s++) send_sample(ALL_F, 0);

        // ---- Min, gap-free then with random idle cycles, same expectations
        for (int g = 0; g < 2; g++) begin
            apply_reset(FN_MIN);
            set_round(5, 3, 8, 4, 6, 9, 7, 5);
            send_round(g != 0); expect_out(128'd3, g ? "min_r1_gaps" : "min_r1");
            set_round(20, 15, 30, 40, 16, 99, 17, 18);
            send_round(g != 0); expect_out(128'd15, g ? "min_r2_gaps" : "min_r2");
        end

        // ---- Avg
        apply_reset(FN_AVG);
        set_round(ALL_F, ALL_F, ALL_F, ALL_F, ALL_F, ALL_F, ALL_F, ALL_F);
        send_round(0); expect_out(ALL_F, "avg_all_f");
        set_round(0, 0, 0, 0, 0, 0, 0, 7);
        send_round(0); expect_out(128'd0, "avg_trunc");
        set_round(1, 2, 3, 4, 5, 6, 7, 8);
        send_round(0); expect_out(128'd4, "avg_1_to_8");

        // ---- Extract: bounds excluded
        apply_reset(FN_EXTRACT);
        send_sample(LOW4, 0);
        send_sample({4'h7, 124'd0}, 0); expect_out({4'h7, 124'd0}, "extract_in");
        send_sample(HIGH4, 0);
        send_sample(HIGH4 - 128'd1, 0); expect_out(HIGH4 - 128'd1, "extract_hi_minus1");
        send_sample({4'h6, 124'd0}, 0);

        // ---- Exclude: bounds excluded
        apply_reset(FN_EXCLUDE);
        send_sample(LOW5, 0);
        send_sample(HIGH5, 0);
        send_sample(128'd0, 0);          expect_out(128'd0, "exclude_zero");
        send_sample(ALL_F, 0);           expect_out(ALL_F, "exclude_all_f");
        send_sample({4'h8, 124'd0}, 0);
        send_sample(LOW5 - 128'd1, 0);   expect_out(LOW5 - 128'd1, "exclude_lo_minus1");
        send_sample(HIGH5 + 128'd1, 0);  expect_out(HIGH5 + 128'd1, "exclude_hi_plus1");

        // ---- PeakMax: round maxima 5,3,5,8 -> outputs 5 then 8
        apply_reset(FN_PMAX);
        set_round(1, 5, 0, 2, 0, 0, 4, 0); send_round(0); expect_out(128'd5, "pmax_r1");
        set_round(3, 1, 0, 2, 0, 0, 0, 0); send_round(0);
        set_round(0, 0, 0, 0, 0, 5, 0, 1); send_round(0);
        set_round(2, 0, 8, 0, 7, 0, 0, 0); send_round(0); expect_out(128'd8, "pmax_r4");

        // ---- PeakMin: round minima 9,12,4,4 -> outputs 9 then 4
        apply_reset(FN_PMIN);
        set_round(20, 9, 30, 40, 50, 60, 70, 80);  send_round(0); expect_out(128'd9, "pmin_r1");
        set_round(12, 20, 30, 40, 50, 60, 70, 13); send_round(0);
        set_round(50, 20, 30, 4, 50, 60, 70, 80);  send_round(0); expect_out(128'd4, "pmin_r3");
        set_round(4, 20, 30, 40, 50, 60, 70, 80);  send_round(0);

        // ---- fn_sel 0: no output at all
        apply_reset(FN_NONE);
        set_round(1, 2, 3, 4, 5, 6, 7, 8); send_round(0);

        // ---- Reset mid-sample discards partial data
        apply_reset(FN_MAX);
        send_sample(128'd100, 0);
        send_sample(128'd200, 0);
        send_sample(128'd50, 0);
        for (int b = 15; b >= 8; b--) send_byte(8'hFF, 0);
        apply_reset(FN_MAX);
        set_round(4, 1, 2, 3, 0, 1, 2, 3); send_round(0); expect_out(128'd4, "max_after_reset");

        repeat (4) @(posedge clk);
        #1 done_flag = 1'b1;
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard backstop so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
